ct_mmu_sysmap_ctrl: RTL
=======================

CT_MMU_SYSMAP_CTRL -- requirements
Module: ct_mmu_sysmap_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH SHALL default to `PA_WIDTH-12 (28); it is the page-number width of every PA port.
REQ-002 Parameter FLG_WIDTH SHALL default to 5; it is the sysmap flag width.
REQ-003 cpuclk  in  1  the only clock; all state SHALL update on its rising edge.
REQ-004 cpurst  in  1  reset, synchronous and active-high.
REQ-005 req_vld  in  3  lookup request valid; bit0 ITLB, bit1 DTLB, bit2 PTW.
REQ-006 req0_pa, req1_pa, req2_pa  in  ADDR_WIDTH each  page number for each requester.
REQ-007 req_rdy  out  3  one-hot grant; a lookup transfers when req_vld[i] and req_rdy[i] are both high.
REQ-008 ctrl_sysmap_pa_y  out  ADDR_WIDTH  registered PA driven to the sysmap lookup.
REQ-009 sysmap_ctrl_flg_y  in  FLG_WIDTH; sysmap_ctrl_hit_y  in  8  combinational sysmap result for ctrl_sysmap_pa_y.
REQ-010 rsp_vld  out  1; rsp_id  out  2; rsp_flg  out  FLG_WIDTH; rsp_hit  out  8  lookup response.
REQ-011 rsp_rdy  in  1  response consumed when rsp_vld and rsp_rdy are both high.
REQ-012 upd_req  in  1  sysmap region registers are about to change; level, held until upd_ack.
REQ-013 upd_ack  out  1  single-cycle pulse: pipeline drained, update may proceed.

Function
REQ-014 At most one req_rdy bit SHALL be high per cycle, and only for a requester with req_vld high.
REQ-015 Arbitration SHALL be 3-way round-robin; after a grant to requester i, priority order SHALL restart at i+1 (mod 3).
REQ-016 Grants SHALL be issued only in IDLE and only when the response slot is empty or rsp_rdy is high in the same cycle (pipelined refill).
REQ-017 On grant in cycle T, the winning PA SHALL be latched into ctrl_sysmap_pa_y and rsp_id at T+1, with rsp_vld high from T+1.
REQ-018 While rsp_vld is high, rsp_flg and rsp_hit SHALL be taken combinationally from the sysmap result; ctrl_sysmap_pa_y and rsp_id SHALL hold until the response handshake completes.
REQ-019 rsp_vld SHALL drop the cycle after a handshake unless a new grant occurred in the handshake cycle; throughput is one lookup per cycle.
REQ-020 The FSM SHALL have states IDLE, DRAIN, ACK and HOLD.
REQ-021 In IDLE with upd_req high, the FSM SHALL enter DRAIN and SHALL issue no grant that cycle; upd_req takes priority over simultaneous req_vld.
REQ-022 In DRAIN, the FSM SHALL enter ACK once rsp_vld is low, or when a handshake completes in that cycle.
REQ-023 In ACK, upd_ack SHALL be high for exactly one cycle, followed by a transition to HOLD.
REQ-024 In HOLD, no grants SHALL be issued and upd_ack SHALL stay low; the FSM SHALL return to IDLE in the first cycle upd_req is low.
REQ-025 If upd_req drops before ACK, the FSM SHALL still complete ACK, then HOLD, then IDLE.
REQ-026 The round-robin pointer SHALL NOT advance in cycles without a grant.

Reset
REQ-027 While cpurst is high, the block SHALL drive: FSM state IDLE, rsp_vld 0, rsp_id 0, ctrl_sysmap_pa_y 0, upd_ack 0, req_rdy 0, and round-robin pointer set so ITLB has highest priority.
REQ-028 Reset asserted mid-operation SHALL discard any held response without a handshake; rsp_vld SHALL be 0 in the cycle after reset is sampled.

Structure
REQ-029 A shared package SHALL hold the requester ID constants (ITLB=0, DTLB=1, PTW=2), the FSM state encoding, ADDR_WIDTH and FLG_WIDTH.
REQ-030 The round-robin grant logic SHALL be the sub-module ct_mmu_sysmap_rr_arb (inputs: req[2:0], pointer advance; output: one-hot grant); everything else is flat.

Verification
REQ-031 Reset, then req_vld=3'b111 held with rsp_rdy=1 -> grants in order ITLB, DTLB, PTW, ITLB on consecutive cycles; rsp_id 0,1,2,0 one cycle later.
REQ-032 Single request from DTLB with pa 0x0000123, rsp_rdy=0 for 3 cycles -> rsp_vld held 3 cycles; pa/id stable; req_rdy=0 during hold; grant resumes in the rsp_rdy cycle.
REQ-033 upd_req and req_vld=3'b001 in the same IDLE cycle -> no grant, DRAIN then ACK; upd_ack is a 1-cycle pulse; no grant until the cycle after upd_req drops.
REQ-034 upd_req while a response is held with rsp_rdy=0 for 2 cycles -> upd_ack asserts exactly one cycle after the handshake cycle.
REQ-035 cpurst pulsed while rsp_vld=1 -> rsp_vld=0, upd_ack=0, state IDLE next cycle; the first post-reset grant goes to ITLB when all requesters are valid.
REQ-036 Sysmap stub returning hit=8'h04, flg=5'b01111 -> rsp_hit and rsp_flg match in the same cycle as rsp_vld.

Source files
------------

// File: rtl/ct_mmu_sysmap_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ct_mmu_sysmap_ctrl_pkg
// Description : Shared constants, requester IDs and FSM encoding for the
//               MMU sysmap lookup controller.
// Revision    : 1.0 - initial release
// ============================================================================
package ct_mmu_sysmap_ctrl_pkg;

    // Physical address width; sysmap works on 4 KiB page numbers.
    localparam int PA_WIDTH   = 40;
    localparam int ADDR_WIDTH = PA_WIDTH - 12;
    localparam int FLG_WIDTH  = 5;
    localparam int NUM_REQ    = 3;

    // Requester IDs, also the bit positions in req_vld / req_rdy.
    localparam logic [1:0] c_id_itlb = 2'd0;
    localparam logic [1:0] c_id_dtlb = 2'd1;
    localparam logic [1:0] c_id_ptw  = 2'd2;

    // Controller FSM encoding.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_ACK   = 2'd2,
        ST_HOLD  = 2'd3
    } sysmap_state_e;

    // Next requester in round-robin order (wraps PTW back to ITLB).
    function automatic logic [1:0] rr_next(input logic [1:0] id);
        return (id == c_id_ptw) ? c_id_itlb : (id + 2'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/ct_mmu_sysmap_rr_arb.sv
`default_nettype none
// ============================================================================
// Module      : ct_mmu_sysmap_rr_arb
// Description : 3-way round-robin arbiter. Grant is combinational from the
//               masked request vector; the priority pointer moves to the
//               requester after the winner only when a grant is taken.
// Revision    : 1.0 - initial release
// ============================================================================
module ct_mmu_sysmap_rr_arb (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_req,
    input  logic       i_adv,
    output logic [2:0] o_gnt
);
    import ct_mmu_sysmap_ctrl_pkg::*;

    logic [1:0] r_ptr;
    logic [1:0] w_c0;
    logic [1:0] w_c1;
    logic [1:0] w_c2;
    logic [1:0] w_gnt_id;

    assign w_c0 = r_ptr;
    assign w_c1 = rr_next(r_ptr);
    assign w_c2 = rr_next(w_c1);

    // Pick the first requesting candidate in pointer order.
    always_comb begin
        o_gnt    = 3'b000;
        w_gnt_id = w_c0;
        if (i_req[w_c0]) begin
            o_gnt[w_c0] = 1'b1;
            w_gnt_id    = w_c0;
        end else if (i_req[w_c1]) begin
            o_gnt[w_c1] = 1'b1;
            w_gnt_id    = w_c1;
        end else if (i_req[w_c2]) begin
            o_gnt[w_c2] = 1'b1;
            w_gnt_id    = w_c2;
        end
    end

    // Priority restarts just after the last winner; frozen on idle cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= c_id_itlb;
        end else if (i_adv && (|o_gnt)) begin
            r_ptr <= rr_next(w_gnt_id);
        end
    end

endmodule
`default_nettype wire

// File: rtl/ct_mmu_sysmap_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : ct_mmu_sysmap_ctrl
// Description : Arbitrates ITLB/DTLB/PTW sysmap lookups onto a single
//               registered PA, returns the combinational sysmap result as a
//               valid/ready response, and drains the pipeline on request so
//               the sysmap region registers can be updated safely.
// Revision    : 1.0 - initial release
// ============================================================================
module ct_mmu_sysmap_ctrl #(
    parameter int ADDR_WIDTH = ct_mmu_sysmap_ctrl_pkg::ADDR_WIDTH,
    parameter int FLG_WIDTH  = ct_mmu_sysmap_ctrl_pkg::FLG_WIDTH
) (
    input  logic                  cpuclk,
    input  logic                  cpurst,
    input  logic [2:0]            req_vld,
    input  logic [ADDR_WIDTH-1:0] req0_pa,
    input  logic [ADDR_WIDTH-1:0] req1_pa,
    input  logic [ADDR_WIDTH-1:0] req2_pa,
    output logic [2:0]            req_rdy,
    output logic [ADDR_WIDTH-1:0] ctrl_sysmap_pa_y,
    input  logic [FLG_WIDTH-1:0]  sysmap_ctrl_flg_y,
    input  logic [7:0]            sysmap_ctrl_hit_y,
    output logic                  rsp_vld,
    output logic [1:0]            rsp_id,
    output logic [FLG_WIDTH-1:0]  rsp_flg,
    output logic [7:0]            rsp_hit,
    input  logic                  rsp_rdy,
    input  logic                  upd_req,
    output logic                  upd_ack
);
    import ct_mmu_sysmap_ctrl_pkg::*;

    sysmap_state_e         r_state;
    sysmap_state_e         w_state_nxt;
    logic                  w_upd_ack;

    logic                  r_rsp_vld;
    logic [1:0]            r_rsp_id;
    logic [ADDR_WIDTH-1:0] r_pa;

    logic                  w_hs;
    logic                  w_slot_free;
    logic                  w_gnt_en;
    logic [2:0]            w_arb_req;
    logic [2:0]            w_gnt;
    logic                  w_gnt_any;
    logic [1:0]            w_gnt_id;
    logic [ADDR_WIDTH-1:0] w_gnt_pa;

    // Response slot can be refilled in the same cycle it is consumed.
    assign w_hs        = r_rsp_vld & rsp_rdy;
    assign w_slot_free = ~r_rsp_vld | rsp_rdy;
    assign w_gnt_en    = (r_state == ST_IDLE) & ~upd_req & w_slot_free & ~cpurst;
    assign w_arb_req   = req_vld & {3{w_gnt_en}};
    assign w_gnt_any   = |w_gnt;

    ct_mmu_sysmap_rr_arb u_arb (
        .clk   (cpuclk),
        .rst   (cpurst),
        .i_req (w_arb_req),
        .i_adv (w_gnt_any),
        .o_gnt (w_gnt)
    );

    // Encode the one-hot winner and select its page number.
    always_comb begin
        w_gnt_id = c_id_itlb;
        w_gnt_pa = req0_pa;
        if (w_gnt[c_id_dtlb]) begin
            w_gnt_id = c_id_dtlb;
            w_gnt_pa = req1_pa;
        end else if (w_gnt[c_id_ptw]) begin
            w_gnt_id = c_id_ptw;
            w_gnt_pa = req2_pa;
        end
    end

    // FSM state register.
    always_ff @(posedge cpuclk) begin
        if (cpurst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state and update-ack decode.
    always_comb begin
        w_state_nxt = r_state;
        w_upd_ack   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (upd_req) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (!r_rsp_vld || w_hs) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                w_upd_ack   = ~cpurst;
                w_state_nxt = ST_HOLD;
            end
            ST_HOLD: begin
                if (!upd_req) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // Response slot: load on grant, clear on handshake, hold otherwise.
    always_ff @(posedge cpuclk) begin
        if (cpurst) begin
            r_rsp_vld <= 1'b0;
            r_rsp_id  <= 2'd0;
            r_pa      <= '0;
        end else if (w_gnt_any) begin
            r_rsp_vld <= 1'b1;
            r_rsp_id  <= w_gnt_id;
            r_pa      <= w_gnt_pa;
        end else if (w_hs) begin
            r_rsp_vld <= 1'b0;
        end
    end

    assign req_rdy          = w_gnt;
    assign upd_ack          = w_upd_ack;
    assign rsp_vld          = r_rsp_vld & ~cpurst;
    assign rsp_id           = r_rsp_id;
    assign ctrl_sysmap_pa_y = r_pa;
    assign rsp_flg          = sysmap_ctrl_flg_y;
    assign rsp_hit          = sysmap_ctrl_hit_y;

endmodule
`default_nettype wire
